inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the in-order RISC-V core. It owns the PC, issues one word request at a time to the instruction-memory port, and queries the branch target buffer combinationally with the address being fetched. It picks the next PC (BTB target on hit, else PC+4) and hands {instruction, PC, prediction} to decode through a one-entry output register with valid/stall flow control. Execute-stage redirects (mispredict, jump) flush the stage and restart fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; 0 freezes every register
- redirect_i  in  1  execute-stage redirect pulse
- redirect_pc_i  in  32  new fetch PC
- stall_i  in  1  decode cannot accept this cycle
- mem_req_o  out  1  fetch request, held until ack
- mem_addr_o  out  32  fetch address, stable while mem_req_o=1
- mem_ack_i  in  1  one-cycle pulse; mem_data_i valid
- mem_data_i  in  32  instruction word
- btb_raddr_o  out  32  BTB lookup address (= mem_addr_o, combinational)
- btb_hit_i  in  1  BTB hit for btb_raddr_o
- btb_target_i  in  32  predicted target
- inst_valid_o  out  1  output register holds an instruction
- inst_o  out  32  instruction
- inst_pc_o  out  32  its PC
- pred_taken_o  out  1  BTB hit at fetch time
- pred_target_o  out  32  BTB target (don't-care if pred_taken_o=0)

## Operation
- Registers: pc, state, mem_addr_o, output register (valid, inst, pc, pred_taken, pred_target).
- Reset: pc=RESET_PC, state=IDLE, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, pred_taken_o=0, pred_target_o=0.
- rdy=0: no register changes; outputs hold. rst overrides rdy.
- Slot free = !inst_valid_o || !stall_i. Transfer to decode = inst_valid_o && !stall_i; transfer clears inst_valid_o unless the same cycle loads a new instruction.
- States (mem_req_o = state!=IDLE):
  - IDLE: redirect_i → pc=redirect_pc_i, stay IDLE. Else if slot free → mem_addr_o=pc, go BUSY. mem_ack_i ignored.
  - BUSY: redirect_i with mem_ack_i → drop data, pc=redirect_pc_i, go IDLE. redirect_i alone → pc=redirect_pc_i, go DROP. mem_ack_i alone → load output register {mem_data_i, mem_addr_o, btb_hit_i, btb_target_i}, valid=1; pc = btb_hit_i ? btb_target_i : mem_addr_o+4; go IDLE.
  - DROP: mem_ack_i → discard, go IDLE. redirect_i → pc=redirect_pc_i (latest wins), stay.
- redirect_i always clears inst_valid_o the same edge; priority redirect > ack > stall.
- Output register is always empty at ack time (issue only when slot free, and only this FSM fills it); no overwrite is possible.
- PC+4 wraps modulo 2^32; bits [1:0] passed through unchanged.

## Timing
- Issue: IDLE with slot free at cycle t → mem_req_o=1, mem_addr_o valid at t+1.
- Ack at t → inst_valid_o=1 at t+1; state IDLE at t+1; next request at t+2 if slot free at t+1. Throughput one instruction per (memory latency + 2) cycles.
- Redirect at t in IDLE → request to redirect_pc_i at t+2 (t+1 IDLE with new pc).
- Redirect at t in BUSY, ack at t+k → IDLE at t+k+1, request for redirect_pc_i at t+k+2; no instruction from the dropped request reaches decode.
- Stall: inst outputs held stable while inst_valid_o && stall_i.

## Structure
- Shared defines: RESET_PC default, InstAddrBus/InstBus widths, state encodings IDLE/BUSY/DROP (2-bit).
- Single flat module; no sub-module. Next-PC mux and adder inline.

## Test plan
- Reset, memory acks 2 cycles after req with 32'h00000013, no stall, no BTB hit → addresses 0,4,8 in order; inst_pc_o 0,4,8; pred_taken_o=0.
- BTB hit on 32'h8 with target 32'h40 → pred_taken_o=1, pred_target_o=32'h40; next mem_addr_o=32'h40.
- stall_i high 5 cycles with inst_valid_o=1 → outputs constant, mem_req_o=0 throughout; resumes one cycle after stall_i falls.
- redirect_i to 32'h100 while BUSY, ack 3 cycles later → acked word never appears; next request 32'h100; inst_valid_o cleared on the redirect edge.
- redirect_i coincident with mem_ack_i → data dropped, next request to redirect_pc_i; second redirect during DROP → last PC used.
- rdy=0 for 4 cycles mid-BUSY, then rst pulse during BUSY → state frozen while rdy=0; after rst, mem_req_o=0, inst_valid_o=0, first request to RESET_PC; a late ack in IDLE is ignored.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  localparam inst_addr_t RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: control, instruction memory, BTB lookup and decode hand-off.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic       rdy;
  logic       redirect_i;
  inst_addr_t redirect_pc_i;
  logic       stall_i;
  logic       mem_req_o;
  inst_addr_t mem_addr_o;
  logic       mem_ack_i;
  inst_t      mem_data_i;
  inst_addr_t btb_raddr_o;
  logic       btb_hit_i;
  inst_addr_t btb_target_i;
  logic       inst_valid_o;
  inst_t      inst_o;
  inst_addr_t inst_pc_o;
  logic       pred_taken_o;
  inst_addr_t pred_target_o;

  modport master (
    input  rdy, redirect_i, redirect_pc_i, stall_i, mem_ack_i, mem_data_i,
           btb_hit_i, btb_target_i,
    output mem_req_o, mem_addr_o, btb_raddr_o, inst_valid_o, inst_o, inst_pc_o,
           pred_taken_o, pred_target_o
  );

  modport slave (
    output rdy, redirect_i, redirect_pc_i, stall_i, mem_ack_i, mem_data_i,
           btb_hit_i, btb_target_i,
    input  mem_req_o, mem_addr_o, btb_raddr_o, inst_valid_o, inst_o, inst_pc_o,
           pred_taken_o, pred_target_o
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding word request, BTB-steered next PC, one-entry
// output register towards decode, flushed by execute-stage redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_t ResetPc = RESET_PC
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  inst_addr_t   addr_q, addr_d;
  logic         valid_q, valid_d;
  inst_t        inst_q, inst_d;
  inst_addr_t   inst_pc_q, inst_pc_d;
  logic         pred_taken_q, pred_taken_d;
  inst_addr_t   pred_target_q, pred_target_d;
  logic         slot_free;

  // Issue only when the output register will be empty by the time the ack lands.
  assign slot_free = !valid_q || !bus.stall_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    valid_d       = valid_q && bus.stall_i;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;

    case (state_q)
      StIdle: begin
        if (bus.redirect_i) begin
          pc_d = bus.redirect_pc_i;
        end else if (slot_free) begin
          addr_d  = pc_q;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.redirect_i) begin
          pc_d    = bus.redirect_pc_i;
          state_d = bus.mem_ack_i ? StIdle : StDrop;
        end else if (bus.mem_ack_i) begin
          inst_d        = bus.mem_data_i;
          inst_pc_d     = addr_q;
          pred_taken_d  = bus.btb_hit_i;
          pred_target_d = bus.btb_target_i;
          valid_d       = 1'b1;
          pc_d          = bus.btb_hit_i ? bus.btb_target_i : addr_q + InstAddrBus'(4);
          state_d       = StIdle;
        end
      end
      StDrop: begin
        // The stale request must still complete before a new one may issue.
        if (bus.redirect_i) pc_d = bus.redirect_pc_i;
        if (bus.mem_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.redirect_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= ResetPc;
      addr_q        <= '0;
      valid_q       <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else if (bus.rdy) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      valid_q       <= valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign bus.mem_req_o     = (state_q != StIdle);
  assign bus.mem_addr_o    = addr_q;
  assign bus.btb_raddr_o   = addr_q;
  assign bus.inst_valid_o  = valid_q;
  assign bus.inst_o        = inst_q;
  assign bus.inst_pc_o     = inst_pc_q;
  assign bus.pred_taken_o  = pred_taken_q;
  assign bus.pred_target_o = pred_target_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: request-level reference model, memory/BTB
// responders, directed scenarios followed by randomized traffic.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if bus ();

  inst_fetch #(.ResetPc(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int lat_fixed = -1;  // -1: random memory latency
  int btb_mode  = 0;   // 0 none, 1 hit on 0x8 -> 0x40, 2 hashed
  int stall_sel = 0;   // 0 none, 1 random, 2 stall whenever valid, 3 always
  bit mem_busy  = 1'b0;
  int mem_cnt   = 0;

  // Reference model: PC, outstanding request (with doomed flag), output register.
  bit          m_live = 1'b0;
  bit          m_busy, m_doomed, m_valid, m_pt;
  logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_ptgt;

  logic [31:0] dq_pc[$];
  logic [31:0] dq_inst[$];
  logic [31:0] dq_tgt[$];
  bit          dq_pt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic model_step();
    bit nv;
    if (rst) begin
      m_live = 1'b1; m_busy = 1'b0; m_doomed = 1'b0; m_valid = 1'b0; m_pt = 1'b0;
      m_pc = RESET_PC; m_addr = '0; m_inst = '0; m_ipc = '0; m_ptgt = '0;
    end else if (m_live && bus.rdy) begin
      nv = m_valid && bus.stall_i;
      if (!m_busy) begin
        if (bus.redirect_i) m_pc = bus.redirect_pc_i;
        else if (!m_valid || !bus.stall_i) begin
          m_busy = 1'b1; m_doomed = 1'b0; m_addr = m_pc;
        end
      end else begin
        if (bus.mem_ack_i) begin
          m_busy = 1'b0;
          if (!m_doomed && !bus.redirect_i) begin
            m_inst = bus.mem_data_i; m_ipc = m_addr;
            m_pt = bus.btb_hit_i; m_ptgt = bus.btb_target_i; nv = 1'b1;
            m_pc = bus.btb_hit_i ? bus.btb_target_i : m_addr + 32'd4;
          end
        end else if (bus.redirect_i) m_doomed = 1'b1;
        if (bus.redirect_i) m_pc = bus.redirect_pc_i;
      end
      if (bus.redirect_i) nv = 1'b0;
      m_valid = nv;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, plus a log of instructions handed to decode.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("mem_req", 32'(bus.mem_req_o), 32'(m_busy));
      chk("mem_addr", bus.mem_addr_o, m_addr);
      chk("btb_raddr", bus.btb_raddr_o, m_addr);
      chk("inst_valid", 32'(bus.inst_valid_o), 32'(m_valid));
      chk("inst", bus.inst_o, m_inst);
      chk("inst_pc", bus.inst_pc_o, m_ipc);
      chk("pred_taken", 32'(bus.pred_taken_o), 32'(m_pt));
      if (m_pt) chk("pred_target", bus.pred_target_o, m_ptgt);
      if (!rst && bus.rdy && bus.inst_valid_o && !bus.stall_i) begin
        dq_pc.push_back(bus.inst_pc_o);
        dq_inst.push_back(bus.inst_o);
        dq_pt.push_back(bus.pred_taken_o);
        dq_tgt.push_back(bus.pred_target_o);
      end
    end
  end

  task automatic step(input bit r_rst, input bit r_rdy, input bit r_redir,
                      input logic [31:0] r_rpc, input bit r_force_ack);
    logic [31:0] a;
    @(posedge clk);
    #1;
    rst               = r_rst;
    bus.rdy           = r_rdy;
    bus.redirect_i    = r_redir;
    bus.redirect_pc_i = r_redir ? r_rpc : $urandom;
    case (stall_sel)
      1:       bus.stall_i = ($urandom_range(0, 2) == 0);
      2:       bus.stall_i = bus.inst_valid_o;
      3:       bus.stall_i = 1'b1;
      default: bus.stall_i = 1'b0;
    endcase
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = $urandom;
    if (r_rst) begin
      mem_busy = 1'b0;
    end else if (r_force_ack) begin
      bus.mem_ack_i = 1'b1;
    end else if (r_rdy && bus.mem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (mem_cnt == 0) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = mem_word(bus.mem_addr_o);
        mem_busy       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    a = bus.btb_raddr_o;
    bus.btb_hit_i    = 1'b0;
    bus.btb_target_i = $urandom;
    if (btb_mode == 1 && a == 32'h8) begin
      bus.btb_hit_i = 1'b1; bus.btb_target_i = 32'h40;
    end else if (btb_mode == 2 && a[6:4] == 3'b101) begin
      bus.btb_hit_i = 1'b1; bus.btb_target_i = a ^ 32'h0000_1230;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wait_req(input bit lvl, input string name, inout bit saw_valid);
    for (int i = 0; i < 40 && bus.mem_req_o !== lvl; i++) begin
      idle_step();
      if (bus.inst_valid_o) saw_valid = 1'b1;
    end
    chk({name, " wait"}, 32'(bus.mem_req_o), 32'(lvl));
  endtask

  task automatic wait_fresh(input string name);
    bit sv;
    sv = 1'b0;
    wait_req(1'b0, name, sv);
    wait_req(1'b1, name, sv);
  endtask

  initial begin
    logic [31:0] cap_inst, cap_pc, a, rpc;
    bit          sv;
    int          sel;

    bus.rdy = 1'b1; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.stall_i = 1'b0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.btb_hit_i = 1'b0; bus.btb_target_i = '0;

    // Reset and straight-line fetch with a 2-cycle memory and one BTB hit.
    lat_fixed = 2; btb_mode = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle_step();
    chk("reset mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("reset inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("reset mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset inst_pc", bus.inst_pc_o, 32'h0);
    chk("reset pred_target", bus.pred_target_o, 32'h0);
    dq_pc.delete(); dq_inst.delete(); dq_pt.delete(); dq_tgt.delete();
    idle_step();
    chk("first req", 32'(bus.mem_req_o), 32'd1);
    chk("first addr", bus.mem_addr_o, RESET_PC);
    for (int i = 0; i < 60 && dq_pc.size() < 4; i++) idle_step();
    chk("delivered count", 32'(dq_pc.size() >= 4), 32'd1);
    if (dq_pc.size() >= 4) begin
      chk("pc0", dq_pc[0], 32'h0);
      chk("pc1", dq_pc[1], 32'h4);
      chk("pc2", dq_pc[2], 32'h8);
      chk("pc3 btb target", dq_pc[3], 32'h40);
      chk("inst0", dq_inst[0], 32'h0000_0013);
      chk("inst2", dq_inst[2], 32'h0000_0813);
      chk("pt1", 32'(dq_pt[1]), 32'd0);
      chk("pt2", 32'(dq_pt[2]), 32'd1);
      chk("tgt2", dq_tgt[2], 32'h40);
      chk("pt3", 32'(dq_pt[3]), 32'd0);
    end

    // Hold decode off for five cycles with a valid instruction.
    stall_sel = 2;
    idle_step();
    for (int i = 0; i < 40 && !bus.inst_valid_o; i++) idle_step();
    chk("stall valid", 32'(bus.inst_valid_o), 32'd1);
    cap_inst = bus.inst_o;
    cap_pc   = bus.inst_pc_o;
    chk("stall req0", 32'(bus.mem_req_o), 32'd0);
    stall_sel = 3;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      chk("stall inst", bus.inst_o, cap_inst);
      chk("stall pc", bus.inst_pc_o, cap_pc);
      chk("stall req", 32'(bus.mem_req_o), 32'd0);
    end
    stall_sel = 0;
    idle_step();
    chk("stall last req", 32'(bus.mem_req_o), 32'd0);
    idle_step();
    chk("resume req", 32'(bus.mem_req_o), 32'd1);
    chk("resume addr", bus.mem_addr_o, (cap_pc == 32'h8) ? 32'h40 : cap_pc + 32'd4);

    // Redirect while the request is outstanding; the late word must be dropped.
    lat_fixed = 3;
    wait_fresh("redir busy");
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
    idle_step();
    chk("redir clears valid", 32'(bus.inst_valid_o), 32'd0);
    chk("redir drop req", 32'(bus.mem_req_o), 32'd1);
    sv = 1'b0;
    wait_req(1'b0, "redir drop", sv);
    wait_req(1'b1, "redir reissue", sv);
    chk("redir new addr", bus.mem_addr_o, 32'h100);
    chk("redir no stale", 32'(sv), 32'd0);

    // Redirect in the same cycle as the ack.
    lat_fixed = 1;
    wait_fresh("redir ack");
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    idle_step();
    chk("redir+ack req", 32'(bus.mem_req_o), 32'd0);
    chk("redir+ack valid", 32'(bus.inst_valid_o), 32'd0);
    idle_step();
    chk("redir+ack addr", bus.mem_addr_o, 32'h200);

    // Two redirects while dropping: the latest one wins.
    lat_fixed = 3;
    wait_fresh("double redir");
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h384, 1'b0);
    sv = 1'b0;
    wait_req(1'b0, "double drop", sv);
    wait_req(1'b1, "double reissue", sv);
    chk("double addr", bus.mem_addr_o, 32'h384);

    // Freeze mid-request, reset while frozen, then a stray ack while idle.
    wait_fresh("freeze");
    a = bus.mem_addr_o;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("frozen req", 32'(bus.mem_req_o), 32'd1);
      chk("frozen addr", bus.mem_addr_o, a);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst req", 32'(bus.mem_req_o), 32'd0);
    chk("rst valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst addr", bus.mem_addr_o, 32'h0);
    idle_step();
    chk("rst first req", 32'(bus.mem_req_o), 32'd1);
    chk("rst first addr", bus.mem_addr_o, RESET_PC);
    chk("late ack ignored", 32'(bus.inst_valid_o), 32'd0);

    // Randomized traffic.
    lat_fixed = -1; btb_mode = 2; stall_sel = 1;
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      rpc = (sel == 0) ? 32'hFFFF_FFFC : (sel == 1) ? $urandom : ($urandom & 32'h0000_0FFC);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0), rpc, 1'b0);
    end
    idle_step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
